// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS class codes, opcodes, funct codes and encode helper
package mips_pkg;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_J    = 3'd4,
    CLS_ADDI = 3'd5
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FULL
  } ctrl_state_e;

  // Codes 6 and 7 carry no instruction.
  function automatic logic class_legal(input logic [2:0] cls);
    return cls <= 3'd5;
  endfunction

  // Pack the request fields into a 32-bit MIPS word; illegal classes give zero.
  function automatic logic [31:0] encode(input logic [2:0] cls, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [25:0] imm);
    logic [31:0] word;
    word = '0;
    case (instr_class_e'(cls))
      CLS_R:    word = {OP_RTYPE, rs, rt, rd, imm[10:6], imm[5:0]};
      CLS_LW:   word = {OP_LW, rs, rt, imm[15:0]};
      CLS_SW:   word = {OP_SW, rs, rt, imm[15:0]};
      CLS_BEQ:  word = {OP_BEQ, rs, rt, imm[15:0]};
      CLS_J:    word = {OP_J, imm[25:0]};
      CLS_ADDI: word = {OP_ADDI, rs, rt, imm[15:0]};
      default:  word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count != FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array needs no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder feeding a buffered memory write port
module instr_encoder
  import mips_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [LW-1:0]     fill_level,
  output logic              err_illegal
);

  localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ALMOST = LW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);

  ctrl_state_e state, state_nxt;
  logic        run;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;

  assign legal    = class_legal(in_class);
  assign enc_word = encode(in_class, in_rs, in_rt, in_rd, in_imm);
  assign in_ready = run && (state != ST_FULL);
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign wr_valid = (fill_level != '0);
  assign pop      = wr_valid && wr_ready;

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(enc_word),
    .pop      (pop),
    .head     (wr_data),
    .count    (fill_level)
  );

  // Hold off requests until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Occupancy-class transitions driven by push/pop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (push) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (push && !pop && fill_level == LVL_ALMOST) state_nxt = ST_FULL;
        else if (pop && !push && fill_level == LVL_ONE) state_nxt = ST_IDLE;
      end
      ST_FULL: begin
        if (pop) state_nxt = (fill_level == LVL_FULL) ? ST_STREAM : ST_FULL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write address: a load beats the post-transfer increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         wr_addr <= '0;
    else if (addr_load) wr_addr <= addr_base;
    else if (pop)       wr_addr <= wr_addr + 1'b1;
  end

  // One-cycle flag for an accepted request with no instruction behind it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_illegal <= 1'b0;
    else        err_illegal <= accept && !legal;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the parameter FIFO_DEPTH, default 4, meaning the number of encoded-word buffer entries (power of two, at least 2).
REQ-002 The block SHALL have the parameter ADDR_W, default 8, meaning the instruction-memory word-address width.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
REQ-005 in_valid  in  1  request holds a valid instruction description.
REQ-006 in_ready  out  1  block can accept a request this cycle.
REQ-007 in_class  in  3  0=R-type, 1=lw, 2=sw, 3=beq, 4=j, 5=addi, 6..7=illegal.
REQ-008 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-009 in_imm  in  26  bits [25:0] are the J target; [15:0] are the I immediate; for R-type, [10:6] are shamt and [5:0] are funct.
REQ-010 addr_load  in  1  load addr_base into the write-address counter.
REQ-011 addr_base  in  ADDR_W  start address.
REQ-012 wr_valid  out  1  wr_data/wr_addr hold a word to be written.
REQ-013 wr_ready  in  1  instruction memory accepts the word.
REQ-014 wr_addr  out  ADDR_W  word address of the current output word.
REQ-015 wr_data  out  32  encoded MIPS instruction word.
REQ-016 fill_level  out  clog2(FIFO_DEPTH)+1  number of buffered words.
REQ-017 err_illegal  out  1  one-cycle pulse when an illegal class is accepted.

Function
REQ-018 Request accept SHALL occur when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when fill_level < FIFO_DEPTH, independent of wr_ready (no same-cycle pass-through when full).
REQ-019 Encoding SHALL be: R = {000000, rs, rt, rd, shamt, funct}; lw/sw/beq/addi = {op, rs, rt, imm[15:0]} with op = 100011/101011/000100/001000; j = {000010, imm[25:0]}.
REQ-020 Encoding SHALL be combinational on the inputs, and the encoded word SHALL be written into the FIFO at the accept edge; it is visible on wr_data with wr_valid=1 at the earliest in the cycle after accept (latency 1).
REQ-021 An illegal class SHALL be accepted (handshake completes), SHALL NOT enter the FIFO, and SHALL pulse err_illegal high for the following cycle.
REQ-022 wr_valid SHALL equal (fill_level != 0), and wr_data SHALL show the FIFO head.
REQ-023 A word SHALL transfer when wr_valid and wr_ready are both 1; on transfer the head is popped and wr_addr increments by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-024 Simultaneous push and pop SHALL leave fill_level unchanged and preserve order.
REQ-025 Control FSM states SHALL be: IDLE (FIFO empty), STREAM (FIFO non-empty, not full), FULL. Transitions SHALL be: push-only increments the level; pop-only decrements it; FULL→STREAM on pop; STREAM→IDLE on pop of the last word.
REQ-026 addr_load SHALL set wr_addr to addr_base at the next edge; if addr_load coincides with a transfer, addr_load SHALL win (the transferred word uses the old address, and the next word uses addr_base).
REQ-027 wr_data and wr_addr SHALL stay stable while wr_valid=1 and wr_ready=0.

Reset
REQ-028 While reset=0, the block SHALL hold: FIFO empty, fill_level=0, wr_valid=0, wr_addr=0, err_illegal=0, in_ready=0, FSM=IDLE.
REQ-029 in_ready SHALL rise in the first cycle after reset deasserts; reset asserted mid-stream SHALL discard all buffered words.

Structure
REQ-030 The class codes, the opcode constants and the funct constants SHALL live in a shared package mips_pkg, which is also used by control.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo (parameterised depth/width), instantiated once.

Verification
REQ-032 lw, rs=2, rt=3, imm=0x0010, wr_ready=1 → next cycle wr_valid=1, wr_data=0x8C430010, wr_addr=0; then wr_addr=1.
REQ-033 R-type, rs=1, rt=2, rd=3, shamt=0, funct=0x20 → wr_data=0x00221820; j with imm=0x0000100 → wr_data=0x08000100.
REQ-034 wr_ready=0 with 5 pushes attempted → after 4 accepts fill_level=4 and in_ready=0; then wr_ready=1 → words drain in order.
REQ-035 in_class=6 → err_illegal pulses for one cycle and fill_level stays 0; beq, rs=4, rt=5, imm=0xFFFF → wr_data=0x1085FFFF.
REQ-036 addr_load with addr_base=0xFF, then 2 transfers → wr_addr 0xFF then 0x00.
REQ-037 reset pulled low with 3 words buffered → wr_valid=0 and fill_level=0 immediately; after release, the first word goes to wr_addr=0.
